// File: rtl/scan_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_chain_pkg
//  Description : Shared constants and helpers for the scan-chain responder.
//                SYNC_STAGES_DEFAULT - default synchroniser depth
//                MIN_SCAN_PHASE      - shortest scan-clock phase (in clk
//                                      cycles) the responder resolves
//                sat_value()         - all-ones value for a counter width
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_chain_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int MIN_SCAN_PHASE      = SYNC_STAGES_DEFAULT + 3;

    // Saturation value of a WIDTH-bit counter, usable in localparams.
    function automatic logic [31:0] sat_value(input int unsigned width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_sync.sv
`default_nettype none
// ============================================================================
//  Module      : scan_sync
//  Description : STAGES-deep single-bit synchroniser with asynchronous
//                active-low reset.
//  Ports       : clk   - destination clock
//                reset - async reset, active low
//                d     - asynchronous input
//                q     - synchronised output
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_sync
    import scan_chain_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/scan_chain_responder.sv
`default_nettype none
// ============================================================================
//  Module      : scan_chain_responder
//  Description : User-design end of a scan chain. Chain signals are
//                synchronised into clk, drive an NUM_IOS-bit shift/capture
//                register, and are forwarded to the next stage.
//  Ports       : clk, reset (async, active low)
//                clk_in / data_in / scan_select_in / latch_enable_in
//                    - chain inputs from the previous stage (asynchronous)
//                clk_out / data_out / scan_select_out / latch_enable_out
//                    - chain outputs to the next stage
//                module_inputs  - latched drive to the user design
//                module_outputs - user-design outputs, captured on select
//                latch_strobe   - one-clk pulse when module_inputs updates
//                shift_count    - saturating shifts since the last latch
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_responder
    import scan_chain_pkg::*;
#(
    parameter int NUM_IOS     = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_in,
    input  logic               data_in,
    input  logic               scan_select_in,
    input  logic               latch_enable_in,
    output logic               clk_out,
    output logic               data_out,
    output logic               scan_select_out,
    output logic               latch_enable_out,
    output logic [NUM_IOS-1:0] module_inputs,
    input  logic [NUM_IOS-1:0] module_outputs,
    output logic               latch_strobe,
    output logic [COUNT_W-1:0] shift_count
);

    localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(sat_value(COUNT_W));

    logic clk_s;
    logic data_s;
    logic sel_s;
    logic le_s;

    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .reset(reset), .d(clk_in),          .q(clk_s)
    );
    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .reset(reset), .d(data_in),         .q(data_s)
    );
    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_sel (
        .clk(clk), .reset(reset), .d(scan_select_in),  .q(sel_s)
    );
    scan_sync #(.STAGES(SYNC_STAGES)) u_sync_le (
        .clk(clk), .reset(reset), .d(latch_enable_in), .q(le_s)
    );

    logic               clk_q;
    logic               le_q;
    logic [NUM_IOS-1:0] shift_reg;

    logic clk_rise;
    logic clk_fall;
    logic le_rise;

    assign clk_rise = clk_s & ~clk_q;
    assign clk_fall = ~clk_s & clk_q;
    assign le_rise  = le_s & ~le_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_q            <= 1'b0;
            le_q             <= 1'b0;
            clk_out          <= 1'b0;
            scan_select_out  <= 1'b0;
            latch_enable_out <= 1'b0;
            shift_reg        <= '0;
            data_out         <= 1'b0;
            module_inputs    <= '0;
            latch_strobe     <= 1'b0;
            shift_count      <= '0;
        end else begin
            clk_q            <= clk_s;
            le_q             <= le_s;
            clk_out          <= clk_s;
            scan_select_out  <= sel_s;
            latch_enable_out <= le_s;
            latch_strobe     <= le_rise;

            if (clk_rise) begin
                if (sel_s) begin
                    shift_reg <= module_outputs;
                end else begin
                    shift_reg <= {shift_reg[NUM_IOS-2:0], data_s};
                end
            end

            // Updating on the fall keeps data_out steady across the next
            // forwarded rise, so downstream sees our pre-shift MSB.
            if (clk_fall) begin
                data_out <= shift_reg[NUM_IOS-1];
            end

            // Non-blocking read of shift_reg gives the pre-shift value even
            // when a rise lands in the same cycle.
            if (le_rise) begin
                module_inputs <= shift_reg;
            end

            if (le_rise) begin
                shift_count <= '0;
            end else if (clk_rise && !sel_s && (shift_count != CNT_MAX)) begin
                shift_count <= shift_count + COUNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_chain_responder
//  Description : Directed self-checking bench: two responders daisy-chained
//                (dut = first stage, dut_b = second stage).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_chain_responder;
    import scan_chain_pkg::*;

    localparam int PH = MIN_SCAN_PHASE + 1;   // scan phase length in clk
    localparam int SS = SYNC_STAGES_DEFAULT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_in = 1'b0;
    logic       data_in = 1'b0;
    logic       sel_in = 1'b0;
    logic       le_in = 1'b0;
    logic [7:0] mod_out = 8'h00;
    logic [7:0] mod_out_b = 8'h00;

    logic       a_clk_out, a_data_out, a_sel_out, a_le_out, a_strobe;
    logic [7:0] a_mod_in, a_count;
    logic       b_clk_out, b_data_out, b_sel_out, b_le_out, b_strobe;
    logic [7:0] b_mod_in, b_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scan_chain_responder dut (
        .clk(clk), .reset(reset),
        .clk_in(clk_in), .data_in(data_in),
        .scan_select_in(sel_in), .latch_enable_in(le_in),
        .clk_out(a_clk_out), .data_out(a_data_out),
        .scan_select_out(a_sel_out), .latch_enable_out(a_le_out),
        .module_inputs(a_mod_in), .module_outputs(mod_out),
        .latch_strobe(a_strobe), .shift_count(a_count)
    );

    scan_chain_responder dut_b (
        .clk(clk), .reset(reset),
        .clk_in(a_clk_out), .data_in(a_data_out),
        .scan_select_in(a_sel_out), .latch_enable_in(a_le_out),
        .clk_out(b_clk_out), .data_out(b_data_out),
        .scan_select_out(b_sel_out), .latch_enable_out(b_le_out),
        .module_inputs(b_mod_in), .module_outputs(mod_out_b),
        .latch_strobe(b_strobe), .shift_count(b_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full scan-clock period: setup while low, rise, high, fall, low.
    task automatic scan_bit(input logic d, input logic sel);
        data_in = d;
        sel_in  = sel;
        tick(PH);
        clk_in = 1'b1;
        tick(PH);
        clk_in = 1'b0;
        tick(PH);
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) scan_bit(v[i], 1'b0);
    endtask

    // Raise latch_enable_in for hold_cycles, then drop it; returns the
    // number of clk cycles the first stage's strobe was high.
    task automatic latch_pulse(input int hold_cycles, output int strobes);
        strobes = 0;
        le_in = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            tick(1);
            if (a_strobe) strobes++;
        end
        le_in = 1'b0;
        for (int i = 0; i < PH; i++) begin
            tick(1);
            if (a_strobe) strobes++;
        end
    endtask

    initial begin
        int          strobes;
        int          ta;
        int          tb;
        logic [8:0]  dout_seq;
        logic [15:0] frame;

        // ---------------- reset state ----------------
        tick(4);
        check("reset_a_outs", {a_clk_out, a_data_out, a_sel_out, a_le_out, a_strobe}, 32'h0);
        check("reset_a_mod_in", a_mod_in, 32'h0);
        check("reset_a_count", a_count, 32'h0);
        check("reset_b_outs", {b_clk_out, b_data_out, b_sel_out, b_le_out, b_strobe, b_count}, 32'h0);
        reset = 1'b1;
        tick(3);

        // ---------------- 1: shift then latch ----------------
        shift_byte(8'hA5);
        check("t1_count_before", a_count, 32'd8);
        latch_pulse(2 * PH, strobes);
        check("t1_mod_in", a_mod_in, 32'hA5);
        check("t1_strobe_cycles", strobes, 32'd1);
        check("t1_count_after", a_count, 32'd0);

        // ---------------- 2: capture then shift out ----------------
        mod_out  = 8'h3C;
        dout_seq = 9'b001111000;     // data_out after capture fall, then 8 shift falls
        scan_bit(1'b0, 1'b1);
        check("t2_sel_fwd", a_sel_out, 32'd1);
        check("t2_dout_cap", a_data_out, {31'd0, dout_seq[8]});
        check("t2_count_cap", a_count, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            scan_bit(1'b0, 1'b0);
            check($sformatf("t2_dout_%0d", i), a_data_out, {31'd0, dout_seq[8-i]});
        end
        check("t2_count", a_count, 32'd8);

        // ---------------- 3: two-stage chain ----------------
        // The first bits shifted travel furthest, so B's byte (0x34) leads.
        frame = 16'h3412;
        for (int i = 15; i >= 0; i--) scan_bit(frame[i], 1'b0);
        ta = -1;
        tb = -1;
        le_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (a_strobe && ta < 0) ta = i;
            if (b_strobe && tb < 0) tb = i;
        end
        le_in = 1'b0;
        tick(PH);
        check("t3_a_mod_in", a_mod_in, 32'h12);
        check("t3_b_mod_in", b_mod_in, 32'h34);
        check("t3_a_strobe_seen", (ta >= 0), 32'd1);
        check("t3_strobe_delay", tb - ta, SS + 1);

        // ---------------- 4: simultaneous rise and latch ----------------
        shift_byte(8'h0F);
        data_in = 1'b1;
        sel_in  = 1'b0;
        tick(PH);
        clk_in = 1'b1;
        le_in  = 1'b1;
        tick(PH);
        check("t4_mod_in", a_mod_in, 32'h0F);
        check("t4_shift_reg", dut.shift_reg, 32'h1F);
        check("t4_count", a_count, 32'd0);
        clk_in = 1'b0;
        le_in  = 1'b0;
        tick(PH);

        // ---------------- 5: reset mid-frame ----------------
        scan_bit(1'b1, 1'b0);
        scan_bit(1'b1, 1'b0);
        scan_bit(1'b1, 1'b0);
        check("t5_count_pre", a_count, 32'd3);
        check("t5_dout_pre", a_data_out, 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("t5_async_mod_in", a_mod_in, 32'h0);
        check("t5_async_count", a_count, 32'h0);
        check("t5_async_outs", {a_clk_out, a_data_out, a_sel_out, a_le_out, a_strobe}, 32'h0);
        check("t5_async_shift_reg", dut.shift_reg, 32'h0);
        tick(3);
        reset = 1'b1;
        tick(3);
        shift_byte(8'hFF);
        latch_pulse(2 * PH, strobes);
        check("t5_mod_in", a_mod_in, 32'hFF);

        // ---------------- 6: saturation and level latch ----------------
        for (int i = 0; i < 254; i++) scan_bit(1'b0, 1'b0);
        check("t6_count_254", a_count, 32'd254);
        scan_bit(1'b0, 1'b0);
        check("t6_count_255", a_count, 32'd255);
        for (int i = 0; i < 45; i++) scan_bit(1'b1, 1'b0);
        check("t6_count_sat", a_count, 32'd255);
        latch_pulse(50, strobes);
        check("t6_level_strobes", strobes, 32'd1);
        check("t6_count_cleared", a_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_chain_responder.md
Name: scan_chain_responder

Overview:
Scan-chain endpoint for the user-design end of the chain: the responder to scan_controller, which is the initiator. Chain signals enter asynchronously, are synchronised into the local clk domain, and drive an NUM_IOS-bit shift/capture register. The register latches inputs into, and captures outputs from, one user design. The conditioned chain signals are forwarded to the next stage, so instances daisy-chain the same way the existing wrappers do.

Parameters:
NUM_IOS, 8, width of the user-design input/output bus and of the shift register (>=2)
SYNC_STAGES, 2, flops per input synchroniser (>=2)
COUNT_W, 8, width of saturating shift counter

Ports:
clk  input  1  local clock; all state is on the rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
clk_in  input  1  scan clock from the previous stage or controller; asynchronous to clk
data_in  input  1  serial scan data from the previous stage
scan_select_in  input  1  1 = parallel capture on the scan-clock rise; 0 = shift
latch_enable_in  input  1  a rising edge transfers the shift register to module_inputs
clk_out  output  1  forwarded synchronised scan clock
data_out  output  1  serial data to the next stage
scan_select_out  output  1  forwarded synchronised select
latch_enable_out  output  1  forwarded synchronised latch enable
module_inputs  output  NUM_IOS  latched drive to the user design
module_outputs  input  NUM_IOS  user-design outputs, captured on select
latch_strobe  output  1  one-clk pulse when module_inputs updates
shift_count  output  COUNT_W  shifts since the last latch; saturates at all-ones

Behaviour:
- Reset (reset=0, async) clears the following to 0: all synchroniser flops, edge-detect flops, shift_reg, data_out, module_inputs, latch_strobe, shift_count, clk_out, scan_select_out, latch_enable_out.
- Synchronisers: each of clk_in, data_in, scan_select_in and latch_enable_in passes through SYNC_STAGES flops. The results are clk_s, data_s, sel_s and le_s.
- Edge detect:
  - One extra flop per signal on clk_s and le_s.
  - clk_rise = clk_s & ~clk_q; clk_fall = ~clk_s & clk_q; le_rise = le_s & ~le_q.
- On clk_rise:
  - sel_s=1: shift_reg <= module_outputs.
  - sel_s=0: shift_reg <= {shift_reg[NUM_IOS-2:0], data_s}. Data enters at bit 0; the MSB leaves first.
  - shift_count increments on shift only, saturating at 2^COUNT_W-1. Capture does not count.
- On clk_fall: data_out <= shift_reg[NUM_IOS-1].
  - data_out is therefore stable across the next forwarded rise.
  - Downstream samples the pre-shift MSB, so all stages shift coherently.
- On le_rise:
  - module_inputs <= shift_reg, using the value before any same-cycle shift.
  - latch_strobe=1 for exactly one clk.
  - shift_count <= 0. This clear has priority over a same-cycle increment.
- Simultaneous clk_rise and le_rise: the latch takes the old shift_reg, the shift/capture still occurs, and the count ends at 0.
- Forwarding:
  - clk_out=clk_s, scan_select_out=sel_s, latch_enable_out=le_s, each registered. Latency is SYNC_STAGES+1 clk from the input pins.
  - data_out is not re-synchronised.
- Timing contract on the initiator:
  - clk_in high and low phases >= SYNC_STAGES+3 clk each.
  - data_in and scan_select_in stable for >= SYNC_STAGES+1 clk before the clk_in rise.
  - latch_enable_in rises only while clk_in is low.
  - Pulses shorter than this are undefined; no detection is required.
- Reset mid-shift: everything clears immediately; the partial frame is lost, and module_inputs reads 0 until the next latch.
- A level-high latch_enable_in produces exactly one latch and one strobe. Re-latching requires a low-then-high transition.

Decomposition:
- Package scan_chain_pkg holds:
  - constants: SYNC_STAGES_DEFAULT=2, MIN_SCAN_PHASE=SYNC_STAGES_DEFAULT+3 (bench timing);
  - a localparam function for the saturation value.
- Sub-module scan_sync:
  - parameterised N-stage, 1-bit synchroniser with async active-low reset;
  - instantiated 4 times.
- Edge detect, shift/capture register, latch and counter stay in scan_chain_responder.

Test Plan:
1. Shift then latch: shift 0xA5 MSB-first with sel=0 over 8 rises, then pulse latch_enable_in. Required: module_inputs=0xA5, latch_strobe high for exactly 1 clk, shift_count reads 8 before the latch and 0 after.
2. Capture: module_outputs=0x3C; one rise with sel=1, then 8 shifts with sel=0 and data_in=0. Required: data_out after successive falls reads 0,0,1,1,1,1,0,0, and shift_count=8.
3. Two-instance chain (A.*_out feeding B.*_in): shift 16 bits 0x12_34 and latch. Required: B.module_inputs=0x34, A.module_inputs=0x12; forwarded latch strobes B SYNC_STAGES+1 clk after A.
4. Simultaneous events: shift_reg holds 0x0F; force clk_rise and le_rise in the same cycle with data_in=1. Required: module_inputs=0x0F, shift_reg=0x1F, shift_count=0.
5. Reset mid-frame: assert reset after 3 shifts, then release. Required: all outputs 0 immediately (asynchronously). A fresh 8-bit shift of 0xFF plus latch then gives module_inputs=0xFF.
6. Saturation/level latch: 300 shifts with no latch give shift_count=255. Holding latch_enable_in high for 50 clk gives one strobe only.
